// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of W external JK flip-flops.
// One command is accepted at a time over cmd_valid/cmd_ready. Each command
// drives the J/K vectors for exactly one DRIVE cycle. A SETTLE cycle with
// J=K=0 follows, so the bank updates once per step. COUNT commands repeat
// DRIVE/SETTLE once per step, and the toggle mask is rebuilt each time from
// the observed q.
// Optional build macro: JK_CTRL_QCHECK_EN. When it is defined, the
// controller predicts the bank value after every step and flags err if q
// disagrees at the end of SETTLE.
module jk_bank_ctrl #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd,
  input  logic [W-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_steps,
  output logic [W-1:0]  j,
  output logic [W-1:0]  k,
  input  logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [W-1:0]  j_q, j_d, k_q, k_d;
  logic          busy_q, busy_d, done_q, done_d, wrap_q, wrap_d, err_q, err_d;
`ifdef JK_CTRL_QCHECK_EN
  logic [W-1:0]  exp_q, exp_d, drv_exp;
`endif

  logic          accept;
  logic [2:0]    sel_op;
  logic [W-1:0]  sel_data;
  logic [W-1:0]  drv_j, drv_k;
  logic          drv_wrap;
  logic          is_count;

  // Bit i toggles on increment when all lower bits are one.
  function automatic logic [W-1:0] up_mask(input logic [W-1:0] v);
    logic [W-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < W; i++) m[i] = m[i-1] & v[i-1];
    return m;
  endfunction

  // Bit i toggles on decrement when all lower bits are zero.
  function automatic logic [W-1:0] down_mask(input logic [W-1:0] v);
    logic [W-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < W; i++) m[i] = m[i-1] & ~v[i-1];
    return m;
  endfunction

  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;

  assign j    = j_q;
  assign k    = k_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
  assign err  = err_q;

  // Drive vector for the step that starts at this edge. In IDLE it comes from
  // the incoming command; on later count steps it comes from the captured one.
  always_comb begin
    sel_op   = (state_q == IDLE) ? cmd : op_q;
    sel_data = (state_q == IDLE) ? cmd_data : data_q;
    drv_j    = '0;
    drv_k    = '0;
    drv_wrap = 1'b0;
`ifdef JK_CTRL_QCHECK_EN
    drv_exp  = q;
`endif
    case (sel_op)
      OP_CLEAR: begin
        drv_k = '1;
`ifdef JK_CTRL_QCHECK_EN
        drv_exp = '0;
`endif
      end
      OP_SET: begin
        drv_j = '1;
`ifdef JK_CTRL_QCHECK_EN
        drv_exp = '1;
`endif
      end
      OP_LOAD: begin
        drv_j = sel_data;
        drv_k = ~sel_data;
`ifdef JK_CTRL_QCHECK_EN
        drv_exp = sel_data;
`endif
      end
      OP_TOGGLE: begin
        drv_j = sel_data;
        drv_k = sel_data;
`ifdef JK_CTRL_QCHECK_EN
        drv_exp = q ^ sel_data;
`endif
      end
      OP_UP: begin
        drv_j    = up_mask(q);
        drv_k    = up_mask(q);
        drv_wrap = (q == '1);
`ifdef JK_CTRL_QCHECK_EN
        drv_exp = q + W'(1);
`endif
      end
      OP_DOWN: begin
        drv_j    = down_mask(q);
        drv_k    = down_mask(q);
        drv_wrap = (q == '0);
`ifdef JK_CTRL_QCHECK_EN
        drv_exp = q - W'(1);
`endif
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    steps_d  = steps_q;
    wrap_d   = wrap_q;
    err_d    = err_q;
    j_d      = '0;
    k_d      = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    is_count = (op_q == OP_UP) || (op_q == OP_DOWN);
`ifdef JK_CTRL_QCHECK_EN
    exp_d    = exp_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = cmd;
          data_d  = cmd_data;
          steps_d = cmd_steps;
          wrap_d  = 1'b0;
          err_d   = 1'b0;
          if (cmd == OP_NOP) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (cmd == OP_RSVD) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if ((cmd == OP_UP || cmd == OP_DOWN) && cmd_steps == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRIVE;
            busy_d  = 1'b1;
            j_d     = drv_j;
            k_d     = drv_k;
            wrap_d  = drv_wrap;
`ifdef JK_CTRL_QCHECK_EN
            exp_d   = drv_exp;
`endif
          end
        end
      end
      DRIVE: begin
        state_d = SETTLE;
        busy_d  = 1'b1;
      end
      SETTLE: begin
`ifdef JK_CTRL_QCHECK_EN
        if (q != exp_q) err_d = 1'b1;
`endif
        if (is_count) steps_d = steps_q - CW'(1);
        if (is_count && steps_q != CW'(1)) begin
          state_d = DRIVE;
          busy_d  = 1'b1;
          j_d     = drv_j;
          k_d     = drv_k;
          wrap_d  = wrap_q | drv_wrap;
`ifdef JK_CTRL_QCHECK_EN
          exp_d   = drv_exp;
`endif
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      steps_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef JK_CTRL_QCHECK_EN
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      steps_q <= steps_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
`ifdef JK_CTRL_QCHECK_EN
      exp_q   <= exp_d;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: a behavioural JK flop bank closes the q loop.
// Expected outcomes are pushed to a scoreboard at command issue and popped
// when done is observed.
module tb_jk_bank_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_UP     = 3'd5;
  localparam logic [2:0] OP_DOWN   = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd = '0;
  logic [W-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_steps = '0;
  logic [W-1:0]  j, k, q_in;
  logic          busy, done, wrap, err;

  logic [W-1:0]  bank_q = '0;
  logic [W-1:0]  stuck_low = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         wrap;
    logic         err;
    int           lat;
    string        name;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] trace[$];
  logic [W-1:0] model_q = '0;

  always #5 clk = ~clk;

  // Behavioural JK flop bank; unaffected by the controller reset.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  assign q_in = bank_q & ~stuck_low;

  jk_bank_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
    .j(j), .k(k), .q(q_in), .busy(busy), .done(done), .wrap(wrap), .err(err)
  );

  // Issue one command and check its completion. Latency is counted the way a
  // synchronous consumer sees it: the number of edges after accept up to the
  // edge at which done is sampled.
  task automatic run_cmd(input string name, input logic [2:0] op,
                         input logic [W-1:0] data, input logic [CW-1:0] steps,
                         input logic [W-1:0] eq, input logic ew, input logic ee,
                         input int elat);
    exp_t e;
    int n;
    bit seen;
    logic [W-1:0] prev, t;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_wait: cmd_ready=%b required 1", name, cmd_ready);
      return;
    end
    e.q = eq; e.wrap = ew; e.err = ee; e.lat = elat; e.name = name;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd = op; cmd_data = data; cmd_steps = steps;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd = 3'($urandom); cmd_data = W'($urandom); cmd_steps = CW'($urandom);
    prev = q_in;
    n = 0;
    seen = 0;
    while (n < 100) begin
      @(negedge clk);
      if (q_in !== prev) begin
        if (trace.size() > 0) begin
          t = trace.pop_front();
          checks++;
          if (q_in !== t) begin
            failures++;
            $display("FAIL %s step_trace: q=%b required %b", name, q_in, t);
          end
        end
        prev = q_in;
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_phase: cmd_ready=%b busy=%b required 0/1", name, cmd_ready, busy);
      end
      @(posedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d cycles", e.name, n);
      return;
    end
    if (n + 1 !== e.lat) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", e.name, n + 1, e.lat);
    end
    checks++;
    if (q_in !== e.q) begin
      failures++;
      $display("FAIL %s q: got %b required %b", e.name, q_in, e.q);
    end
    checks++;
    if (wrap !== e.wrap) begin
      failures++;
      $display("FAIL %s wrap: got %b required %b", e.name, wrap, e.wrap);
    end
    checks++;
    if (err !== e.err) begin
      failures++;
      $display("FAIL %s err: got %b required %b", e.name, err, e.err);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b required 0", e.name, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_done: done=%b cmd_ready=%b required 0/1", e.name, done, cmd_ready);
    end
    model_q = eq;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({j, k, busy, done, wrap, err, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_state: j=%b k=%b busy=%b done=%b wrap=%b err=%b ready=%b required all 0",
               j, k, busy, done, wrap, err, cmd_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  // COUNT_UP 5 from 0000, rst lands during the SETTLE after the second step.
  task automatic test_reset_mid_count();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = OP_UP; cmd_data = '0; cmd_steps = 8'd5;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({j, k, busy, done, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL midrst_state: j=%b k=%b busy=%b done=%b ready=%b required all 0",
               j, k, busy, done, cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || q_in !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_release: ready=%b q=%b required 1/0010", cmd_ready, q_in);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q_in !== 4'b0010 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hold: q=%b busy=%b done=%b required 0010/0/0", q_in, busy, done);
    end
    model_q = 4'b0010;
  endtask

  task automatic test_clear_load();
    run_cmd("clear", OP_CLEAR, 4'b0110, 8'd0, 4'b0000, 1'b0, 1'b0, 3);
    run_cmd("load_1010", OP_LOAD, 4'b1010, 8'd0, 4'b1010, 1'b0, 1'b0, 3);
  endtask

  task automatic test_toggle();
    run_cmd("toggle", OP_TOGGLE, 4'b0110, 8'd0, 4'b1100, 1'b0, 1'b0, 3);
    run_cmd("set", OP_SET, 4'b0000, 8'd0, 4'b1111, 1'b0, 1'b0, 3);
  endtask

  task automatic test_count_up();
    run_cmd("load_1101", OP_LOAD, 4'b1101, 8'd0, 4'b1101, 1'b0, 1'b0, 3);
    trace.push_back(4'b1110);
    trace.push_back(4'b1111);
    trace.push_back(4'b0000);
    trace.push_back(4'b0001);
    trace.push_back(4'b0010);
    run_cmd("count_up5", OP_UP, 4'b0000, 8'd5, 4'b0010, 1'b1, 1'b0, 11);
    checks++;
    if (trace.size() != 0) begin
      failures++;
      $display("FAIL count_up5 trace_left: %0d steps unseen required 0", trace.size());
      trace.delete();
    end
  endtask

  task automatic test_count_down();
    run_cmd("load_0", OP_LOAD, 4'b0000, 8'd0, 4'b0000, 1'b0, 1'b0, 3);
    run_cmd("count_down1", OP_DOWN, 4'b0000, 8'd1, 4'b1111, 1'b1, 1'b0, 3);
    run_cmd("count_up0", OP_UP, 4'b0000, 8'd0, 4'b1111, 1'b0, 1'b0, 1);
    run_cmd("nop", OP_NOP, 4'b0101, 8'd3, 4'b1111, 1'b0, 1'b0, 1);
  endtask

  task automatic test_illegal();
    run_cmd("opcode7", OP_RSVD, 4'b0101, 8'd2, model_q, 1'b0, 1'b1, 1);
    run_cmd("err_clear", OP_LOAD, 4'b0100, 8'd0, 4'b0100, 1'b0, 1'b0, 3);
  endtask

  task automatic test_qcheck();
    stuck_low = 4'b0001;
`ifdef JK_CTRL_QCHECK_EN
    run_cmd("qcheck_stuck", OP_LOAD, 4'b0001, 8'd0, 4'b0000, 1'b0, 1'b1, 3);
`else
    run_cmd("qcheck_off", OP_LOAD, 4'b0001, 8'd0, 4'b0000, 1'b0, 1'b0, 3);
`endif
    stuck_low = 4'b0000;
    run_cmd("qcheck_recover", OP_LOAD, 4'b1001, 8'd0, 4'b1001, 1'b0, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    logic [2:0]    op;
    logic [W-1:0]  data, eq;
    logic [CW-1:0] steps;
    logic          ew;
    int            lat, sum;
    for (int i = 0; i < 12; i++) begin
      op    = 3'($urandom_range(1, 6));
      data  = W'($urandom);
      steps = CW'($urandom_range(0, 3));
      ew    = 1'b0;
      lat   = 3;
      case (op)
        OP_CLEAR:  eq = '0;
        OP_SET:    eq = '1;
        OP_LOAD:   eq = data;
        OP_TOGGLE: eq = model_q ^ data;
        OP_UP: begin
          sum = int'(model_q) + int'(steps);
          ew  = (sum > 15);
          eq  = W'(sum % 16);
          lat = 2 * int'(steps) + 1;
        end
        default: begin
          sum = int'(model_q) - int'(steps) + 16;
          ew  = (int'(steps) > int'(model_q));
          eq  = W'(sum % 16);
          lat = 2 * int'(steps) + 1;
        end
      endcase
      run_cmd($sformatf("rand%0d_op%0d", i, op), op, data, steps, eq, ew, 1'b0, lat);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_clear_load();
    test_toggle();
    test_count_up();
    test_count_down();
    test_illegal();
    test_qcheck();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
